// File: rtl/sram_pkg.sv
// Shared definitions for the external SRAM controller: op codes, FSM states
// and the lane/extension helpers. The helpers are reused by the cache.
package sram_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WSETUP = 3'd2,
        ST_WPULSE = 3'd3,
        ST_WHOLD  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Active-high lane enables; half ops look only at off[1].
    function automatic logic [3:0] be_of(input logic [3:0] op, input logic [1:0] off);
        logic [3:0] be;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << off;
            OP_LH, OP_LHU, OP_SH: be = off[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data copied into every lane the access may select.
    function automatic logic [31:0] replicate(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] r;
        case (op)
            OP_SB:   r = {4{d[7:0]}};
            OP_SH:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LW:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic m;
        case (op)
            OP_LH, OP_LHU, OP_SH: m = off[0];
            OP_LW, OP_SW:         m = (off != 2'b00);
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_load_align.sv
// Combinational load lane extraction with sign/zero extension.
module sram_load_align
    import sram_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    // Select the addressed lane(s) and extend to 32 bits.
    always_comb begin
        data_o = extend(op_i, off_i, word_i);
    end

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle controller for an external asynchronous 32-bit SRAM.
// Optional build macro: SRAM_MISALIGN_TRAP_EN (adds misalign_o and skips
// misaligned half/word accesses).
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int READ_WAIT   = 2,
    parameter int WRITE_PULSE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_op_i,
    input  logic [21:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic [19:0] sram_addr_o,
    output logic [31:0] sram_data_o,
    output logic        sram_data_oe_o,
    input  logic [31:0] sram_data_i,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o
`ifdef SRAM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int CNT_W = 8;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         off_q, off_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic [3:0]         be_n_q, be_n_d;
    logic [19:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               data_oe_q, data_oe_d;
    logic               done_q, done_d;
    logic [31:0]        load_q, load_d;
`ifdef SRAM_MISALIGN_TRAP_EN
    logic               misalign_q, misalign_d;
`endif
    logic               op_valid_s;
    logic               trap_s;
    logic [31:0]        align_data_s;

    sram_load_align u_align (
        .op_i   (op_q),
        .off_i  (off_q),
        .word_i (sram_data_i),
        .data_o (align_data_s)
    );

    // Classify the incoming op and decide whether it traps as misaligned.
    always_comb begin
        op_valid_s = is_load(mem_op_i) || is_store(mem_op_i);
`ifdef SRAM_MISALIGN_TRAP_EN
        trap_s = is_misaligned(mem_op_i, addr_i[1:0]);
`else
        trap_s = 1'b0;
`endif
    end

    // Next-state and next-output logic; pins are registered from these.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        be_n_d    = be_n_q;
        addr_d    = addr_q;
        data_d    = data_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        load_d    = load_q;
`ifdef SRAM_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_valid_s && trap_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`ifdef SRAM_MISALIGN_TRAP_EN
                    misalign_d = 1'b1;
`endif
                end else if (op_valid_s) begin
                    op_d   = mem_op_i;
                    off_d  = addr_i[1:0];
                    addr_d = addr_i[21:2];
                    ce_n_d = 1'b0;
                    be_n_d = ~be_of(mem_op_i, addr_i[1:0]);
                    if (is_load(mem_op_i)) begin
                        state_d = ST_READ;
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_W'(READ_WAIT - 1);
                    end else begin
                        state_d   = ST_WSETUP;
                        data_d    = replicate(mem_op_i, store_data_i);
                        data_oe_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    load_d  = align_data_s;
                    state_d = ST_DONE;
                    oe_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    be_n_d  = 4'hF;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WSETUP: begin
                state_d = ST_WPULSE;
                we_n_d  = 1'b0;
                cnt_d   = CNT_W'(WRITE_PULSE - 1);
            end
            ST_WPULSE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_WHOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WHOLD: begin
                state_d   = ST_DONE;
                data_oe_d = 1'b0;
                ce_n_d    = 1'b1;
                be_n_d    = 4'hF;
                done_d    = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                ce_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                we_n_d    = 1'b1;
                be_n_d    = 4'hF;
                data_oe_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered SRAM pins; reset forces every strobe high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            off_q     <= 2'b00;
            cnt_q     <= {CNT_W{1'b0}};
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= 4'hF;
            addr_q    <= 20'h00000;
            data_q    <= 32'h0000_0000;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            load_q    <= 32'h0000_0000;
`ifdef SRAM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            load_q    <= load_d;
`ifdef SRAM_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Stall is combinational so the pipeline freezes in the request cycle.
    always_comb begin
        stall_o = rst && (((state_q == ST_IDLE) && op_valid_s) ||
                          (state_q == ST_READ)   || (state_q == ST_WSETUP) ||
                          (state_q == ST_WPULSE) || (state_q == ST_WHOLD));
    end

    assign done_o         = done_q;
    assign load_data_o    = load_q;
    assign sram_addr_o    = addr_q;
    assign sram_data_o    = data_q;
    assign sram_data_oe_o = data_oe_q;
    assign sram_ce_n_o    = ce_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_we_n_o    = we_n_q;
    assign sram_be_n_o    = be_n_q;
`ifdef SRAM_MISALIGN_TRAP_EN
    assign misalign_o     = misalign_q;
`endif

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Drives the external asynchronous 32-bit SRAM on behalf of the MEM stage.
- Takes the memory op, physical byte address and store data that the MMU produces, and runs a multi-cycle read or write FSM on the SRAM pins.
- Returns sign- or zero-extended load data to the pipeline, and stalls the pipeline while an access is in flight.

Parameters:
- READ_WAIT, 2: cycles oe_n is held low before read data is sampled (min 1).
- WRITE_PULSE, 2: cycles we_n is held low (min 1).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- mem_op_i  in  4  op code from the MMU (sram_pkg encoding).
- addr_i  in  22  physical byte address; [21:2] is the word address, [1:0] the byte offset.
- store_data_i  in  32  store data, right-aligned.
- stall_o  out  1  pipeline stall request.
- done_o  out  1  one-cycle pulse: access complete.
- load_data_o  out  32  extended load result, valid while done_o is high.
- sram_addr_o  out  20  SRAM word address.
- sram_data_o  out  32  write data bus.
- sram_data_oe_o  out  1  tri-state enable for sram_data_o (1 = drive).
- sram_data_i  in  32  read data bus.
- sram_ce_n_o  out  1  chip enable, active low.
- sram_oe_n_o  out  1  output enable, active low.
- sram_we_n_o  out  1  write enable, active low.
- sram_be_n_o  out  4  byte enables, active low.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all SRAM strobes high; sram_be_n_o=4'hF; sram_addr_o=0; sram_data_o=0; sram_data_oe_o=0; load_data_o=0; done_o=0. stall_o=0 while rst=0.
- Op encoding: NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8. Codes 9-15 are treated as NOP.
- Byte enables:
  - Byte ops: the lane addressed by addr_i[1:0].
  - Half ops: lanes {1,0} if addr_i[1]=0, else {3,2}.
  - Word ops: all lanes.
  - Store data is replicated into the selected lanes.
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, DONE.
- IDLE:
  - On a non-NOP op, latch op, addr[1:0] and data, drive sram_addr_o, and go to READ (loads) or WSETUP (stores).
  - sram_ce_n_o=0 from the next cycle onward.
- READ:
  - oe_n=0, be_n per op.
  - Lasts READ_WAIT cycles, counted by a down-counter.
  - On the last cycle, sram_data_i is extracted by lane, extended (LB/LH sign-extend, LBU/LHU zero-extend) and registered into load_data_o. Then go to DONE.
- WSETUP: 1 cycle; data_oe=1, we_n=1, oe_n=1.
- WPULSE: WRITE_PULSE cycles with we_n=0.
- WHOLD: 1 cycle; we_n=1, data still driven, then go to DONE.
- DONE:
  - 1 cycle; done_o=1, ce_n=1, data_oe=0; always returns to IDLE.
  - The op presented during DONE is ignored, so the same op is never re-executed.
- stall_o is combinational: 1 when (IDLE and op is not NOP) or state is READ, WSETUP, WPULSE or WHOLD; otherwise 0.
- Latency in stall cycles: load = 1+READ_WAIT; store = 3+WRITE_PULSE.
- The requester must hold mem_op_i, addr_i and store_data_i stable while stall_o=1. Changes during an access are ignored because the values are latched.
- we_n and oe_n are never low in the same cycle.
- data_oe is never high while oe_n is low.
- Reset mid-access: strobes return high immediately (asynchronous) and the access is abandoned.
- load_data_o holds its value until the next load completes.

Optional Feature:
- SRAM_MISALIGN_TRAP_EN.
  - Defined: a halfword op with addr_i[0]=1 or a word op with addr_i[1:0]!=0 skips the SRAM. The FSM goes IDLE->DONE, strobes stay high, and an extra output misalign_o pulses with done_o (1 stall cycle).
  - Undefined: no misalign_o port; the address LSBs are ignored for halfword/word lane selection (word ops use addr[21:2] only, half ops use addr[1] only).

Decomposition:
- sram_pkg holds:
  - the op-code constants;
  - the state enum;
  - helper functions is_load(op), is_store(op), be_of(op, off) and extend(op, off, word).
- One sub-module, sram_load_align: combinational lane extraction plus sign/zero extension. It is reused later by the cache.

Test Plan:
- SW 0xDEADBEEF to addr 0x000010 (READ_WAIT=2, WRITE_PULSE=2) -> sram_addr_o=0x00004, be_n=0000, we_n low for exactly 2 cycles, stall_o high 5 cycles, done_o pulses once.
- Then LW from 0x000010 with the SRAM model -> load_data_o=0xDEADBEEF, oe_n low 2 cycles, stall 3 cycles, we_n stays high.
- SB 0x80 at 0x000013, then LB and LBU at 0x000013 -> be_n=0111 on the write; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH 0x8001 at 0x000012, then LH -> be_n=0011, sram_data_o[31:16]=0x8001; LH returns 0xFFFF8001.
- Assert rst low during WPULSE -> we_n, ce_n and oe_n go high the same cycle, data_oe=0; after release the FSM is in IDLE and the next LW completes normally.
- With SRAM_MISALIGN_TRAP_EN: LW at 0x000002 -> no ce_n assertion, misalign_o=1 with done_o, stall 1 cycle.
